alu_result_ascii_tx: RTL and testbench
======================================

Name: alu_result_ascii_tx

Overview:
- Downstream stage of the UART/ALU interface FSM: converts the ALU result into a multi-digit decimal ASCII string and pushes it byte by byte into the UART TX FIFO.
- Replaces the single-character "result + 48" output, which is only valid for results 0..9.
- Sits between the ALU output / interface FSM (source of `start` and `result`) and the UART TX FIFO write port (`wr_uart`, `tx_full`).

Parameters:
- N, 8: result width in bits; legal range 4..8, so at most 3 decimal digits.
- SIGNED, 0: 1 = treat `result` as two's complement and emit '-' for negatives; 0 = unsigned.
- SEND_CRLF, 1: 1 = append CR (13) then LF (10) after the last digit.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to transmit `result`.
- result  input  N  ALU result; sampled only on an accepted start.
- tx_full  input  1  UART TX FIFO full flag.
- tx_data  output  8  ASCII byte to the TX FIFO; valid when wr_uart=1.
- wr_uart  output  1  TX FIFO write strobe; one byte per high cycle.
- busy  output  1  high while a conversion or transmission is in progress.
- done  output  1  one-cycle pulse after the final byte is written.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, wr_uart=0, tx_data=0; digit counters, remainder and char index cleared.
- Reset mid-operation aborts immediately. No further writes occur after release; the bytes already written stay in the FIFO.
- States: IDLE, CONV, SEND, FIN.
- IDLE:
  - start=1 latches result, goes to CONV.
  - If SIGNED=1 and result[N-1]=1: set neg flag; remainder = two's-complement magnitude, zero-extended to 8 bits (N=8: 0x80 gives 128).
  - Otherwise remainder = result zero-extended.
  - hund=0, tens=0.
- CONV, one subtraction per cycle:
  - if rem>=100: rem-=100, hund++;
  - else if rem>=10: rem-=10, tens++;
  - else go to SEND with char index=0.
  - Duration: hund+tens+1 cycles.
- SEND, character sequence in order:
  - '-' only if neg.
  - hund+48 only if hund!=0.
  - tens+48 if hund!=0 or tens!=0.
  - rem+48 always, so a value of 0 emits "0".
  - CR, LF only if SEND_CRLF=1.
- SEND write rules:
  - wr_uart = (state==SEND) & ~tx_full, combinational.
  - tx_data = the current character; it is held stable while tx_full=1.
  - The char index advances only on cycles where wr_uart=1.
  - After the last character is written, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE). It is high from the cycle after start through the FIN cycle.
- start while busy=1 is ignored; no queueing. `result` changing while busy has no effect.
- tx_full=1 stalls SEND indefinitely with no byte loss or duplication. tx_full is not examined in IDLE/CONV/FIN.
- start and reset deasserting in the same edge: start is ignored.
- Max string length: 6 bytes ("-128\r\n").
- Latency, start edge to first wr_uart with tx_full=0: 1 (latch) + hund+tens+1 (CONV) cycles. Subsequent bytes go one per cycle.

Test Plan:
- SIGNED=0, result=42, tx_full=0 -> wr_uart bytes 0x34,0x32,0x0D,0x0A on 4 consecutive cycles; CONV lasts 5 cycles; done pulses once; busy falls after FIN.
- result=0 -> bytes 0x30,0x0D,0x0A. result=255 -> 0x32,0x35,0x35,0x0D,0x0A. result=105 -> 0x31,0x30,0x35,0x0D,0x0A (embedded zero kept).
- SIGNED=1: result=0xFF -> "-1\r\n" (0x2D,0x31,0x0D,0x0A); result=0x80 -> "-128\r\n"; result=0x7F -> "127\r\n".
- result=123, tx_full held high 3 cycles during SEND after the first byte -> byte sequence still exactly 0x31,0x32,0x33,0x0D,0x0A; tx_data stable during the stall; no write while full.
- start pulsed again while busy with result=9 -> ignored; the original string completes; a later start with 9 yields "9\r\n". With SEND_CRLF=0, result=7 -> single byte 0x37.
- reset=0 asserted after the 2nd byte of "255\r\n" -> outputs zero immediately, no further wr_uart; after release a start with 3 yields "3\r\n".

Source files
------------

// File: rtl/alu_result_ascii_tx.sv
// ALU result to decimal ASCII string, written byte by byte into a UART TX FIFO.
// Digits come from repeated subtraction; the string is walked slot by slot.
module alu_result_ascii_tx #(
    parameter int N         = 8,
    parameter bit SIGNED    = 1'b0,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] result,
    input  logic         tx_full,
    output logic [7:0]   tx_data,
    output logic         wr_uart,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, CONV, SEND, FIN} state_t;

    // Slot map: 0 '-', 1 hundreds, 2 tens, 3 units, 4 CR, 5 LF
    localparam logic [2:0] LAST = SEND_CRLF ? 3'd5 : 3'd3;

    state_t     r_state;
    logic       r_neg;
    logic [1:0] r_hund;
    logic [3:0] r_tens;
    logic [7:0] r_rem;
    logic [2:0] r_idx;
    logic       r_done;

    logic         w_neg;
    logic [N-1:0] w_abs;
    logic [7:0]   w_mag;
    logic [5:0]   w_en;
    logic [2:0]   w_first;
    logic [2:0]   w_next;
    logic         w_last;
    logic [7:0]   w_char;

    assign w_neg = SIGNED & result[N-1];
    assign w_abs = w_neg ? (~result + 1'b1) : result;
    assign w_mag = 8'(w_abs);

    assign w_en = {SEND_CRLF, SEND_CRLF, 1'b1,
                   (r_hund != 2'd0) || (r_tens != 4'd0),
                   (r_hund != 2'd0), r_neg};

    always_comb begin
        w_first = 3'd3;
        for (int i = 3; i >= 0; i--)
            if (w_en[i]) w_first = 3'(i);
        w_next = r_idx;
        for (int i = 5; i >= 0; i--)
            if (w_en[i] && (3'(i) > r_idx)) w_next = 3'(i);
    end

    assign w_last = (r_idx == LAST);

    always_comb begin
        w_char = 8'd0;
        if (r_state == SEND) begin
            case (r_idx)
                3'd0:    w_char = 8'h2D;
                3'd1:    w_char = {6'd0, r_hund} + 8'd48;
                3'd2:    w_char = {4'd0, r_tens} + 8'd48;
                3'd3:    w_char = r_rem + 8'd48;
                3'd4:    w_char = 8'h0D;
                3'd5:    w_char = 8'h0A;
                default: w_char = 8'd0;
            endcase
        end
    end

    assign tx_data = w_char;
    assign wr_uart = (r_state == SEND) & ~tx_full;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_neg   <= 1'b0;
            r_hund  <= 2'd0;
            r_tens  <= 4'd0;
            r_rem   <= 8'd0;
            r_idx   <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CONV;
                        r_neg   <= w_neg;
                        r_rem   <= w_mag;
                        r_hund  <= 2'd0;
                        r_tens  <= 4'd0;
                    end
                end
                CONV: begin
                    if (r_rem >= 8'd100) begin
                        r_rem  <= r_rem - 8'd100;
                        r_hund <= r_hund + 2'd1;
                    end else if (r_rem >= 8'd10) begin
                        r_rem  <= r_rem - 8'd10;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_state <= SEND;
                        r_idx   <= w_first;
                    end
                end
                SEND: begin
                    if (!tx_full) begin
                        if (w_last) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= w_next;
                        end
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_ascii_tx.sv
// Bench for alu_result_ascii_tx: unsigned, signed and no-CRLF instances,
// table of results with expected strings fed through a byte scoreboard.
module tb_alu_result_ascii_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] result;
    logic       tx_full;
    int         sel;

    logic       st   [3];
    logic [7:0] td   [3];
    logic       wr   [3];
    logic       bz   [3];
    logic       dn   [3];

    logic [7:0] tx_data;
    logic       wr_uart, busy, done;

    always #5 clk = ~clk;

    assign st[0] = start && (sel == 0);
    assign st[1] = start && (sel == 1);
    assign st[2] = start && (sel == 2);

    assign tx_data = td[sel];
    assign wr_uart = wr[sel];
    assign busy    = bz[sel];
    assign done    = dn[sel];

    alu_result_ascii_tx #(.N(8), .SIGNED(1'b0), .SEND_CRLF(1'b1)) u_uns (
        .clk(clk), .reset(reset), .start(st[0]), .result(result),
        .tx_full(tx_full), .tx_data(td[0]), .wr_uart(wr[0]),
        .busy(bz[0]), .done(dn[0]));

    alu_result_ascii_tx #(.N(8), .SIGNED(1'b1), .SEND_CRLF(1'b1)) u_sgn (
        .clk(clk), .reset(reset), .start(st[1]), .result(result),
        .tx_full(tx_full), .tx_data(td[1]), .wr_uart(wr[1]),
        .busy(bz[1]), .done(dn[1]));

    alu_result_ascii_tx #(.N(8), .SIGNED(1'b0), .SEND_CRLF(1'b0)) u_ncr (
        .clk(clk), .reset(reset), .start(st[2]), .result(result),
        .tx_full(tx_full), .tx_data(td[2]), .wr_uart(wr[2]),
        .busy(bz[2]), .done(dn[2]));

    typedef struct {
        int         sel;
        logic [7:0] val;
        string      txt;
        bit         crlf;
        int         lat;
        int         stall_after;
        int         rst_after;
        bit         extra;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] q [$];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic run(input vec_t v);
        int         n = 0, cyc = 0, stall = 0, dones = 0, first = -1;
        bit         fin = 0, was_full = 0;
        logic [7:0] prev = 8'd0;
        string      tag;
        tag = $sformatf("v%0d/%0d", v.sel, v.val);
        for (int i = 0; i < v.txt.len(); i++) q.push_back(v.txt[i]);
        if (v.crlf) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        sel = v.sel;
        @(negedge clk);
        start   = 1'b1;
        result  = v.val;
        tx_full = 1'b0;
        while (!fin && cyc < 80) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (v.extra && cyc == 3) begin
                start  = 1'b1;
                result = 8'd9;
            end
            tx_full = (stall > 0);
            if (stall > 0) stall--;
            #1;
            if (cyc == 1) chk({tag, " busy_after_start"}, busy, 1);
            if (tx_full) chk({tag, " wr_while_full"}, wr_uart, 0);
            if (tx_full && was_full) chk({tag, " stall_hold"}, tx_data, prev);
            if (wr_uart) begin
                if (first < 0) first = cyc;
                if (q.size() == 0) chk({tag, " extra_byte"}, tx_data, 8'hFF);
                else chk({tag, " byte"}, tx_data, q.pop_front());
                n++;
                if (n == v.stall_after) stall = 3;
            end
            if (done) dones++;
            if (dones > 0 && !done) begin
                chk({tag, " busy_after_fin"}, busy, 0);
                fin = 1;
            end
            prev     = tx_data;
            was_full = tx_full;
            if (v.rst_after > 0 && n == v.rst_after) begin
                @(posedge clk);
                #1;
                reset = 1'b0;
                #1;
                chk({tag, " rst_out"}, {tx_data, wr_uart, busy, done}, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1;
                    chk({tag, " rst_no_wr"}, wr_uart, 0);
                end
                @(negedge clk);
                reset = 1'b1;
                q.delete();
                fin = 1;
            end
        end
        start = 1'b0;
        if (!fin) chk({tag, " timeout"}, cyc, 0);
        if (v.lat > 0) chk({tag, " latency"}, first, v.lat);
        if (v.rst_after <= 0) chk({tag, " done_pulses"}, dones, 1);
        chk({tag, " queue_empty"}, q.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{0, 8'd42,   "42",   1'b1, 6, -1, -1, 1'b0};
        vecs[1]  = '{0, 8'd0,    "0",    1'b1, 2, -1, -1, 1'b0};
        vecs[2]  = '{0, 8'd255,  "255",  1'b1, 9, -1, -1, 1'b0};
        vecs[3]  = '{0, 8'd105,  "105",  1'b1, 3, -1, -1, 1'b0};
        vecs[4]  = '{1, 8'hFF,   "-1",   1'b1, 2, -1, -1, 1'b0};
        vecs[5]  = '{1, 8'h80,   "-128", 1'b1, 5, -1, -1, 1'b0};
        vecs[6]  = '{1, 8'h7F,   "127",  1'b1, 5, -1, -1, 1'b0};
        vecs[7]  = '{2, 8'd7,    "7",    1'b0, 2, -1, -1, 1'b0};
        vecs[8]  = '{0, 8'd123,  "123",  1'b1, 5,  1, -1, 1'b0};
        vecs[9]  = '{0, 8'd200,  "200",  1'b1, 4, -1, -1, 1'b1};
        vecs[10] = '{0, 8'd9,    "9",    1'b1, 2, -1, -1, 1'b0};
        vecs[11] = '{0, 8'd255,  "255",  1'b1, 9, -1,  2, 1'b0};
        vecs[12] = '{0, 8'd3,    "3",    1'b1, 2, -1, -1, 1'b0};

        reset   = 1'b0;
        start   = 1'b0;
        result  = 8'd0;
        tx_full = 1'b0;
        sel     = 0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset_state%0d", s),
                {tx_data, wr_uart, busy, done}, 0);
        end
        sel = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 13; i++) run(vecs[i]);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
